counter_xb: RTL and testbench
=============================

Name: counter_xb

Overview:
- Parametrised, registered up/down counter. It is the sequential successor of the team's 5-bit combinational incrementer.
- It adds the following over the incrementer:
  - configurable width and step
  - direction control
  - synchronous parallel load
  - wrap or saturate mode
  - carry/borrow pulse and sticky overflow flag
- Used by the ALU sequencing logic as a loop/operand index counter and as a general-purpose event counter.

Parameters:
- WIDTH, 5, counter width in bits; legal range 2..32.
- STEP, 1, increment/decrement amount; legal range 1..2^WIDTH-1; elaboration error outside range.
- RESET_VAL, 0, value loaded into out on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count this cycle when high.
- up  input  1  1 = add STEP, 0 = subtract STEP.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo 2^WIDTH.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value taken on load.
- clear_ovf  input  1  clears sticky ovf.
- out  output  WIDTH  registered count.
- carry  output  1  registered one-cycle pulse: the previous update crossed a bound (wrapped or clamped).
- ovf  output  1  sticky: set by any carry event, held until cleared.
- at_max  output  1  out == 2^WIDTH-1 (combinational from out register).
- at_min  output  1  out == 0 (combinational from out register).

Behaviour:
- Single clock domain. All state updates on rising clk. Reset is synchronous and active-high.
- Reset (highest priority):
  - out <= RESET_VAL, carry <= 0, ovf <= 0.
  - Reset asserted mid-count overrides load/enable that cycle.
- Priority per cycle: reset > load > enable > hold.
- Load:
  - out <= load_val, carry <= 0, ovf unchanged.
  - enable ignored that cycle; load never produces a carry.
- Count (enable=1, load=0): compute sum in WIDTH+1 bits.
  - up=1, no crossing (out+STEP <= 2^WIDTH-1): out <= out+STEP, carry <= 0.
  - up=1, crossing, wrap mode: out <= (out+STEP) mod 2^WIDTH, carry <= 1.
  - up=1, crossing, saturate mode: out <= 2^WIDTH-1, carry <= 1.
  - up=0, no crossing (out >= STEP): out <= out-STEP, carry <= 0.
  - up=0, crossing, wrap mode: out <= (out-STEP) mod 2^WIDTH, carry <= 1.
  - up=0, crossing, saturate mode: out <= 0, carry <= 1.
- Saturate edge cases:
  - Already at max and counting up: out holds, carry pulses every enabled cycle.
  - Same at min counting down.
- Hold (enable=0, load=0): out unchanged, carry <= 0.
- Latency: one cycle from input sample to out/carry. carry is high for exactly one cycle per crossing event. Consecutive crossings give consecutive high cycles.
- ovf:
  - Set in the same cycle carry is set.
  - clear_ovf=1 clears it the next edge.
  - Simultaneous new carry event and clear_ovf: set wins, ovf=1.
- Mode/direction are sampled each cycle; changing them mid-count is legal and affects only that cycle's update.
- at_max/at_min follow out with no added latency; both are valid after reset.
- No X propagation: all outputs defined from the first edge with reset asserted.

Test Plan:
- Reset: WIDTH=5, RESET_VAL=0; assert reset with load=1, load_val=9 -> out=0, carry=0, ovf=0, at_min=1.
- Wrap up, WIDTH=5, STEP=1: load 30, enable, up=1 for 3 cycles -> out 31, 0, 1.
  - carry high only in the cycle out=0; ovf=1 from then; at_max=1 while out=31.
- Saturate down, STEP=3, sat_mode=1: load 4, up=0, enable 3 cycles -> out 1, 0, 0.
  - carry pulses in cycles 2 and 3; ovf=1.
- Wrap down, STEP=3: load 1, up=0, enable 1 cycle -> out=30, carry=1.
- Priority: load=1, load_val=7, enable=1, up=1 with out=31 -> out=7, carry=0, ovf unchanged.
  - Then reset=1 with enable=1 -> out=RESET_VAL.
- ovf clear race: clear_ovf=1 in the same cycle as a wrap event -> ovf stays 1.
  - clear_ovf=1 with no event next cycle -> ovf=0.

Source files
------------

// File: rtl/counter_xb_if.sv
// counter_xb_if: control/status bundle for counter_xb.
//   Control (master -> slave): enable, up, sat_mode, load, load_val[WIDTH], clear_ovf
//   Status  (slave -> master): out[WIDTH], carry, ovf, at_max, at_min
// clk and reset are not part of the bundle; they stay plain ports on the counter.
interface counter_xb_if #(
  parameter int WIDTH = 5
);
  logic             enable;
  logic             up;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clear_ovf;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             ovf;
  logic             at_max;
  logic             at_min;

  modport master (
    output enable, up, sat_mode, load, load_val, clear_ovf,
    input  out, carry, ovf, at_max, at_min
  );

  modport slave (
    input  enable, up, sat_mode, load, load_val, clear_ovf,
    output out, carry, ovf, at_max, at_min
  );
endinterface

// File: rtl/counter_xb.sv
// counter_xb: registered up/down counter with a configurable width and step.
// It supports a synchronous parallel load and either a wrap mode or a
// saturate mode. It also provides a one-cycle carry/borrow pulse and a sticky
// overflow flag.
//   clk        rising-edge clock
//   reset      synchronous, active-high; loads RESET_VAL and clears carry/ovf
//   bus.enable count this cycle      bus.up       1 = +STEP, 0 = -STEP
//   bus.sat_mode 1 = clamp at bounds, 0 = wrap mod 2^WIDTH
//   bus.load / bus.load_val  parallel load (beats enable, never carries)
//   bus.clear_ovf  clears sticky ovf (a new carry event the same cycle wins)
//   bus.out    registered count      bus.carry  bound crossed on last update
//   bus.ovf    sticky carry          bus.at_max / bus.at_min  decoded from out
// Per-cycle priority: reset > load > enable > hold.
module counter_xb #(
  parameter int          WIDTH     = 5,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input logic         clk,
  input logic         reset,
  counter_xb_if.slave bus
);

  // Elaboration-time parameter checks
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_xb: WIDTH must be in 2..32");
  end
  if (STEP < 1 || 64'(STEP) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_step
    $error("counter_xb: STEP must be in 1..2^WIDTH-1");
  end
  if (64'(RESET_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_rst
    $error("counter_xb: RESET_VAL does not fit in WIDTH bits");
  end
  if ($bits(bus.out) != WIDTH) begin : g_bad_if
    $error("counter_xb: interface WIDTH does not match counter WIDTH");
  end

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] MIN_V  = '0;
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_nxt_out;
  logic             w_cross;
  logic             w_evt;

  // Use one extra bit so that the MSB directly gives the carry-out or the borrow.
  assign w_sum  = {1'b0, r_out} + STEP_X;
  assign w_diff = {1'b0, r_out} - STEP_X;

  always_comb begin
    w_nxt_out = r_out;
    w_cross   = 1'b0;
    if (bus.up) begin
      w_cross   = w_sum[WIDTH];
      w_nxt_out = (w_cross && bus.sat_mode) ? MAX_V : w_sum[WIDTH-1:0];
    end else begin
      w_cross   = w_diff[WIDTH];
      w_nxt_out = (w_cross && bus.sat_mode) ? MIN_V : w_diff[WIDTH-1:0];
    end
  end

  // A crossing event exists only for a real count; a load hides it.
  assign w_evt = bus.enable & ~bus.load & w_cross;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= RST_V;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.load)        r_out <= bus.load_val;
      else if (bus.enable) r_out <= w_nxt_out;
      r_carry <= w_evt;
      // When set and clear occur together, set wins.
      r_ovf   <= w_evt | (r_ovf & ~bus.clear_ovf);
    end
  end

  assign bus.out    = r_out;
  assign bus.carry  = r_carry;
  assign bus.ovf    = r_ovf;
  assign bus.at_max = (r_out == MAX_V);
  assign bus.at_min = (r_out == MIN_V);

endmodule

// File: tb/tb_counter_xb.sv
module tb_counter_xb;
  localparam int W  = 5;
  localparam int MX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic enable, up, sat_mode, load, clear_ovf;
  logic [W-1:0] load_val;

  always #5 clk = ~clk;

  // dut a: STEP=1, RESET_VAL=0 ; dut b: STEP=3, RESET_VAL=5
  counter_xb_if #(.WIDTH(W)) ifa ();
  counter_xb_if #(.WIDTH(W)) ifb ();

  assign ifa.enable = enable;   assign ifb.enable = enable;
  assign ifa.up = up;           assign ifb.up = up;
  assign ifa.sat_mode = sat_mode; assign ifb.sat_mode = sat_mode;
  assign ifa.load = load;       assign ifb.load = load;
  assign ifa.load_val = load_val; assign ifb.load_val = load_val;
  assign ifa.clear_ovf = clear_ovf; assign ifb.clear_ovf = clear_ovf;

  counter_xb #(.WIDTH(W), .STEP(1), .RESET_VAL(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  counter_xb #(.WIDTH(W), .STEP(3), .RESET_VAL(5)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one entry per DUT, plain integer arithmetic
  int m_step [2] = '{1, 3};
  int m_rv   [2] = '{0, 5};
  int m_out  [2];
  int m_car  [2];
  int m_ovf  [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int t;
      if (reset) begin
        m_out[k] = m_rv[k]; m_car[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        m_out[k] = int'(load_val); m_car[k] = 0;
        if (clear_ovf) m_ovf[k] = 0;
      end else if (enable) begin
        t = up ? m_out[k] + m_step[k] : m_out[k] - m_step[k];
        m_car[k] = (t > MX || t < 0) ? 1 : 0;
        if (t > MX)     m_out[k] = sat_mode ? MX : t - (MX + 1);
        else if (t < 0) m_out[k] = sat_mode ? 0  : t + (MX + 1);
        else            m_out[k] = t;
        if (m_car[k] == 1) m_ovf[k] = 1;
        else if (clear_ovf) m_ovf[k] = 0;
      end else begin
        m_car[k] = 0;
        if (clear_ovf) m_ovf[k] = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic ld, input int lv, input logic en,
                       input logic u, input logic s, input logic c);
    reset = r; load = ld; load_val = W'(lv); enable = en; up = u; sat_mode = s; clear_ovf = c;
  endtask

  // One clock: let the DUT sample, advance the model, then settle before checks
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 9, 1, 1, 0, 0);
    tick();
    n_vec++; if (ifa.out !== 5'd0) begin n_err++; $display("FAIL reset_out got %0d want 0", ifa.out); end
    n_vec++; if (ifa.carry !== 1'b0 || ifa.ovf !== 1'b0) begin n_err++; $display("FAIL reset_flags got c=%b o=%b want 0 0", ifa.carry, ifa.ovf); end
    n_vec++; if (ifa.at_min !== 1'b1 || ifa.at_max !== 1'b0) begin n_err++; $display("FAIL reset_minmax got min=%b max=%b want 1 0", ifa.at_min, ifa.at_max); end
    n_vec++; if (ifb.out !== 5'd5) begin n_err++; $display("FAIL reset_val_b got %0d want 5", ifb.out); end
  endtask

  task automatic test_wrap_up();
    int eo [3] = '{31, 0, 1};
    int ec [3] = '{0, 1, 0};
    int ev [3] = '{0, 1, 1};
    int em [3] = '{1, 0, 0};
    drive(0, 1, 30, 0, 1, 0, 0);
    tick();
    n_vec++; if (ifa.out !== 5'd30) begin n_err++; $display("FAIL load30 got %0d want 30", ifa.out); end
    drive(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (ifa.out !== W'(eo[i]) || ifa.carry !== ec[i][0] || ifa.ovf !== ev[i][0] || ifa.at_max !== em[i][0]) begin
        n_err++;
        $display("FAIL wrap_up[%0d] got out=%0d c=%b o=%b max=%b want %0d %0d %0d %0d",
                 i, ifa.out, ifa.carry, ifa.ovf, ifa.at_max, eo[i], ec[i], ev[i], em[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic eov;
    drive(0, 1, 31, 0, 1, 0, 0);
    tick();
    eov = m_ovf[0][0];
    drive(0, 1, 7, 1, 1, 0, 0);
    tick();
    n_vec++;
    if (ifa.out !== 5'd7 || ifa.carry !== 1'b0 || ifa.ovf !== eov) begin
      n_err++; $display("FAIL load_prio got out=%0d c=%b o=%b want 7 0 %b", ifa.out, ifa.carry, ifa.ovf, eov);
    end
    drive(1, 0, 0, 1, 1, 0, 0);
    tick();
    n_vec++;
    if (ifa.out !== 5'd0 || ifb.out !== 5'd5 || ifa.ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_prio got a=%0d b=%0d o=%b want 0 5 0", ifa.out, ifb.out, ifa.ovf);
    end
  endtask

  task automatic test_sat_down();
    int eo [3] = '{1, 0, 0};
    int ec [3] = '{0, 1, 1};
    drive(0, 1, 4, 0, 0, 1, 1);
    tick();
    n_vec++; if (ifb.out !== 5'd4 || ifb.ovf !== 1'b0) begin n_err++; $display("FAIL sat_setup got out=%0d o=%b want 4 0", ifb.out, ifb.ovf); end
    drive(0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (ifb.out !== W'(eo[i]) || ifb.carry !== ec[i][0] || ifb.ovf !== (i > 0)) begin
        n_err++;
        $display("FAIL sat_down[%0d] got out=%0d c=%b o=%b want %0d %0d %0d", i, ifb.out, ifb.carry, ifb.ovf, eo[i], ec[i], i > 0);
      end
    end
    // At max while counting up with saturation, the count holds and carry pulses every cycle.
    drive(0, 1, 31, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (ifa.out !== 5'd31 || ifa.carry !== 1'b1) begin
        n_err++; $display("FAIL sat_hold_max[%0d] got out=%0d c=%b want 31 1", i, ifa.out, ifa.carry);
      end
    end
  endtask

  task automatic test_wrap_down();
    drive(0, 1, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    n_vec++;
    if (ifb.out !== 5'd30 || ifb.carry !== 1'b1) begin
      n_err++; $display("FAIL wrap_down got out=%0d c=%b want 30 1", ifb.out, ifb.carry);
    end
  endtask

  task automatic test_ovf_race();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 31, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0, 1);
    tick();
    n_vec++;
    if (ifa.out !== 5'd0 || ifa.carry !== 1'b1 || ifa.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_race got out=%0d c=%b o=%b want 0 1 1", ifa.out, ifa.carry, ifa.ovf);
    end
    drive(0, 0, 0, 0, 1, 0, 1);
    tick();
    n_vec++;
    if (ifa.ovf !== 1'b0 || ifa.carry !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear got o=%b c=%b want 0 0", ifa.ovf, ifa.carry);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), int'($urandom_range(0, MX)),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0));
      tick();
      n_vec++;
      if (ifa.out !== W'(m_out[0]) || ifa.carry !== m_car[0][0] || ifa.ovf !== m_ovf[0][0] ||
          ifa.at_max !== (m_out[0] == MX) || ifa.at_min !== (m_out[0] == 0)) begin
        n_err++;
        $display("FAIL rand_a[%0d] got out=%0d c=%b o=%b max=%b min=%b want %0d %0d %0d",
                 n, ifa.out, ifa.carry, ifa.ovf, ifa.at_max, ifa.at_min, m_out[0], m_car[0], m_ovf[0]);
      end
      n_vec++;
      if (ifb.out !== W'(m_out[1]) || ifb.carry !== m_car[1][0] || ifb.ovf !== m_ovf[1][0] ||
          ifb.at_max !== (m_out[1] == MX) || ifb.at_min !== (m_out[1] == 0)) begin
        n_err++;
        $display("FAIL rand_b[%0d] got out=%0d c=%b o=%b max=%b min=%b want %0d %0d %0d",
                 n, ifb.out, ifb.carry, ifb.ovf, ifb.at_max, ifb.at_min, m_out[1], m_car[1], m_ovf[1]);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin m_out[k] = 0; m_car[k] = 0; m_ovf[k] = 0; end
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_priority();
    test_sat_down();
    test_wrap_down();
    test_ovf_race();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
